// File: rtl/status_led_pkg.sv
// rtl/status_led_pkg.sv - shared mode encodings and counter-width helper for status_led_ctrl
// Contents:
//   MODE_W                          width of one channel's mode field
//   MODE_OFF/MODE_ON/MODE_HB/MODE_EVT  per-channel mode encodings
//   cnt_width(v)                    bits needed to hold 0..v
package status_led_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ON  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_HB  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_EVT = 2'b11;

    function automatic int cnt_width(input int v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// rtl/led_stretch_ch.sv - one channel's event pulse stretcher (reload/decrement counter)
// Ports:
//   CLK     in   system clock
//   RST_N   in   asynchronous reset, active low
//   enable  in   channel is in event-stretch mode; counter is held at 0 otherwise
//   evt     in   one-cycle event strobe; (re)loads the counter with STRETCH_CYCLES
//   lit     out  counter value being loaded at this edge is non-zero
module led_stretch_ch
    import status_led_pkg::*;
#(
    parameter int STRETCH_CYCLES = 1200000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic enable,
    input  logic evt,
    output logic lit
);

    localparam int              CW   = cnt_width(STRETCH_CYCLES);
    localparam logic [CW-1:0]   LOAD = CW'(STRETCH_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!enable) begin
            w_cnt_nxt = '0;
        end else if (evt) begin
            w_cnt_nxt = LOAD;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Reported from the next-state value so the registered LED in the top
    // lights on the same edge that samples the event: exactly STRETCH_CYCLES
    // lit cycles, and a retrigger reload leaves no gap.
    assign lit = (w_cnt_nxt != '0);

endmodule

// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - N-channel status LED controller (off/on/heartbeat/event stretch, sticky error blink)
// Optional feature macro: STATUS_LED_PWM_EN (4-bit PWM brightness gating by duty)
// Ports:
//   CLK        in   system clock
//   RST_N      in   asynchronous reset, active low
//   evt_pulse  in   [N_LEDS]    per-channel one-cycle event strobe
//   mode_sel   in   [2*N_LEDS]  per-channel mode, [2i+1:2i] for channel i
//   err_in     in   error strobe, sets the sticky error (wins over err_clr)
//   err_clr    in   clears the sticky error
//   duty       in   [4]         PWM brightness 0..15 (only with STATUS_LED_PWM_EN)
//   err_flag   out  sticky error state
//   LED        out  [N_LEDS]    registered LED drive, active high
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int N_LEDS         = 8,
    parameter int HEARTBEAT_DIV  = 6000000,
    parameter int STRETCH_CYCLES = 1200000,
    parameter int ERR_DIV        = 1500000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_LEDS-1:0]     evt_pulse,
    input  logic [2*N_LEDS-1:0]   mode_sel,
    input  logic                  err_in,
    input  logic                  err_clr,
    input  logic [3:0]            duty,
    output logic                  err_flag,
    output logic [N_LEDS-1:0]     LED
);

    localparam int              HB_W    = cnt_width(HEARTBEAT_DIV);
    localparam int              EB_W    = cnt_width(ERR_DIV);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_DIV - 1);
    localparam logic [EB_W-1:0] EB_LAST = EB_W'(ERR_DIV - 1);

    logic [HB_W-1:0]   r_hb_cnt, w_hb_cnt_nxt;
    logic              r_hb, w_hb_nxt;
    logic [EB_W-1:0]   r_eb_cnt, w_eb_cnt_nxt;
    logic              r_eb, w_eb_nxt;
    logic              r_err_flag, w_err_nxt;
    logic [N_LEDS-1:0] r_led, w_led_nxt;
    logic [N_LEDS-1:0] w_mode_led;

    // The output register is fed from next-state hb/eb/error values so every
    // LED change lands on the same edge as the event that causes it.
    always_comb begin
        w_hb_cnt_nxt = r_hb_cnt + HB_W'(1);
        w_hb_nxt     = r_hb;
        if (r_hb_cnt == HB_LAST) begin
            w_hb_cnt_nxt = '0;
            w_hb_nxt     = ~r_hb;
        end
    end

    // Error blink prescaler only runs while the error is latched, so each
    // error episode starts its blink from a dark phase.
    always_comb begin
        w_eb_cnt_nxt = '0;
        w_eb_nxt     = 1'b0;
        if (r_err_flag) begin
            w_eb_cnt_nxt = r_eb_cnt + EB_W'(1);
            w_eb_nxt     = r_eb;
            if (r_eb_cnt == EB_LAST) begin
                w_eb_cnt_nxt = '0;
                w_eb_nxt     = ~r_eb;
            end
        end
    end

    assign w_err_nxt = err_in | (r_err_flag & ~err_clr);

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        logic [MODE_W-1:0] w_mode;
        logic              w_lit;
        logic              w_bit;

        assign w_mode = mode_sel[MODE_W*i +: MODE_W];

        led_stretch_ch #(
            .STRETCH_CYCLES (STRETCH_CYCLES)
        ) u_stretch (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .enable (w_mode == MODE_EVT),
            .evt    (evt_pulse[i]),
            .lit    (w_lit)
        );

        always_comb begin
            w_bit = 1'b0;
            case (w_mode)
                MODE_OFF: w_bit = 1'b0;
                MODE_ON:  w_bit = 1'b1;
                MODE_HB:  w_bit = w_hb_nxt;
                MODE_EVT: w_bit = w_lit;
                default:  w_bit = 1'b0;
            endcase
        end

        assign w_mode_led[i] = w_bit;
    end

    // Error overrides all channels; stretch counters keep running underneath.
    assign w_led_nxt = w_err_nxt ? {N_LEDS{w_eb_nxt}} : w_mode_led;

`ifdef STATUS_LED_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic       w_pwm_on;

    assign w_pwm_on = (r_pwm_cnt < duty);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end
`else
    logic w_pwm_on;
    logic w_duty_unused;

    assign w_pwm_on      = 1'b1;
    assign w_duty_unused = ^duty;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hb_cnt   <= '0;
            r_hb       <= 1'b0;
            r_eb_cnt   <= '0;
            r_eb       <= 1'b0;
            r_err_flag <= 1'b0;
            r_led      <= '0;
        end else begin
            r_hb_cnt   <= w_hb_cnt_nxt;
            r_hb       <= w_hb_nxt;
            r_eb_cnt   <= w_eb_cnt_nxt;
            r_eb       <= w_eb_nxt;
            r_err_flag <= w_err_nxt;
            r_led      <= w_led_nxt & {N_LEDS{w_pwm_on}};
        end
    end

    assign err_flag = r_err_flag;
    assign LED      = r_led;

endmodule

// File: tb/tb_status_led_ctrl.sv
// tb/tb_status_led_ctrl.sv - self-checking bench for status_led_ctrl against a cycle-count reference model
module tb_status_led_ctrl;

    localparam int N   = 4;
    localparam int HB  = 4;
    localparam int STR = 3;
    localparam int ED  = 2;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic [N-1:0]   evt_pulse;
    logic [2*N-1:0] mode_sel;
    logic           err_in;
    logic           err_clr;
    logic [3:0]     duty;
    logic           err_flag;
    logic [N-1:0]   LED;

    always #5 CLK = ~CLK;

    status_led_ctrl #(
        .N_LEDS         (N),
        .HEARTBEAT_DIV  (HB),
        .STRETCH_CYCLES (STR),
        .ERR_DIV        (ED)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .evt_pulse (evt_pulse),
        .mode_sel  (mode_sel),
        .err_in    (err_in),
        .err_clr   (err_clr),
        .duty      (duty),
        .err_flag  (err_flag),
        .LED       (LED)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: edges since reset release, edge index of each channel's
    // latest accepted event, and the edge at which the error was latched.
    int           n;
    int           last_evt [N];
    bit           err_m;
    int           set_edge;
    logic [N-1:0] exp_led;
    logic         exp_err;

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < N; i++) last_evt[i] = -1000;
        err_m    = 1'b0;
        set_edge = 0;
        exp_led  = '0;
        exp_err  = 1'b0;
    endtask

    task automatic tick();
        logic [N-1:0] pre;
        @(posedge CLK);
        n++;
        pre = '0;
        for (int i = 0; i < N; i++) begin
            int m;
            m = int'(mode_sel[2*i +: 2]);
            if (m != 3)            last_evt[i] = -1000;
            else if (evt_pulse[i]) last_evt[i] = n;
            case (m)
                0:       pre[i] = 1'b0;
                1:       pre[i] = 1'b1;
                2:       pre[i] = ((n / HB) % 2) == 1;
                default: pre[i] = (n - last_evt[i]) < STR;
            endcase
        end
        if (err_in) begin
            if (!err_m) set_edge = n;
            err_m = 1'b1;
        end else if (err_clr) begin
            err_m = 1'b0;
        end
        if (err_m) pre = (((n - set_edge) / ED) % 2 == 1) ? '1 : '0;
`ifdef STATUS_LED_PWM_EN
        if (!(((n - 1) % 16) < int'(duty))) pre = '0;
`endif
        exp_led = pre;
        exp_err = err_m;
        #1;
    endtask

    task automatic test_reset();
        mode_sel = 8'h55;
        err_in   = 1'b1;
        tick();
        err_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (LED !== exp_led || err_flag !== exp_err) begin
                $display("FAIL reset_prerun k=%0d led=%h err=%b exp led=%h err=%b", k, LED, err_flag, exp_led, exp_err);
                miscompares++;
            end
            tick();
        end
        #2 RST_N = 1'b0;
        #1;
        vectors++;
        if (LED !== 4'h0 || err_flag !== 1'b0) begin
            $display("FAIL reset_async led=%h err=%b exp led=0 err=0", LED, err_flag);
            miscompares++;
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (LED !== 4'h0) begin
            $display("FAIL reset_held led=%h exp 0", LED);
            miscompares++;
        end
        mode_sel = 8'b10101010;
        #3 RST_N = 1'b1;
        model_reset();
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (LED !== exp_led || err_flag !== exp_err) begin
                $display("FAIL heartbeat k=%0d led=%h err=%b exp led=%h err=%b", k, LED, err_flag, exp_led, exp_err);
                miscompares++;
            end
            if (k == 4 || k == 8) begin
                vectors++;
                if (LED !== ((k == 4) ? 4'hF : 4'h0)) begin
                    $display("FAIL heartbeat_edge k=%0d led=%h exp %h", k, LED, (k == 4) ? 4'hF : 4'h0);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_stretch();
        int lit_cnt;
        mode_sel  = 8'b00000011;
        evt_pulse = '0;
        tick(); tick(); tick();
        // single pulse: lit for exactly STR cycles
        evt_pulse[0] = 1'b1;
        lit_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            evt_pulse = '0;
            lit_cnt += int'(LED[0]);
            vectors++;
            if (LED !== exp_led) begin
                $display("FAIL stretch_single k=%0d led=%h exp %h", k, LED, exp_led);
                miscompares++;
            end
        end
        vectors++;
        if (lit_cnt != STR) begin
            $display("FAIL stretch_len got %0d exp %0d", lit_cnt, STR);
            miscompares++;
        end
        // retrigger two cycles later: one unbroken pulse of 2+STR cycles
        lit_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            evt_pulse[0] = (k == 0 || k == 2);
            tick();
            lit_cnt += int'(LED[0]);
            vectors++;
            if (LED !== exp_led) begin
                $display("FAIL stretch_retrig k=%0d led=%h exp %h", k, LED, exp_led);
                miscompares++;
            end
        end
        evt_pulse = '0;
        vectors++;
        if (lit_cnt != STR + 2) begin
            $display("FAIL retrig_len got %0d exp %0d", lit_cnt, STR + 2);
            miscompares++;
        end
        mode_sel = 8'hFF;
        for (int k = 0; k < 40; k++) begin
            evt_pulse = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            tick();
            vectors++;
            if (LED !== exp_led) begin
                $display("FAIL stretch_rand k=%0d led=%h exp %h", k, LED, exp_led);
                miscompares++;
            end
        end
        evt_pulse = '0;
    endtask

    task automatic test_mode_gating();
        mode_sel = 8'b00000100;
        for (int k = 0; k < 6; k++) begin
            evt_pulse = N'($urandom_range(0, 15));
            tick();
            vectors++;
            if (LED[1] !== 1'b1 || LED !== exp_led) begin
                $display("FAIL gate_on k=%0d led=%h exp %h", k, LED, exp_led);
                miscompares++;
            end
        end
        evt_pulse = '0;
        mode_sel  = 8'b00001100;
        tick();
        vectors++;
        if (LED[1] !== 1'b0 || LED !== exp_led) begin
            $display("FAIL gate_switch_dark led=%h exp %h", LED, exp_led);
            miscompares++;
        end
    endtask

    task automatic test_error();
        mode_sel = 8'h55;
        err_in   = 1'b1;
        tick();
        err_in = 1'b0;
        vectors++;
        if (err_flag !== 1'b1) begin
            $display("FAIL err_set err=%b exp 1", err_flag);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (LED !== exp_led || err_flag !== exp_err) begin
                $display("FAIL err_blink k=%0d led=%h err=%b exp led=%h err=%b", k, LED, err_flag, exp_led, exp_err);
                miscompares++;
            end
            tick();
        end
        err_in  = 1'b1;
        err_clr = 1'b1;
        tick();
        err_in = 1'b0;
        vectors++;
        if (err_flag !== 1'b1 || LED !== exp_led) begin
            $display("FAIL err_set_wins err=%b led=%h exp err=1 led=%h", err_flag, LED, exp_led);
            miscompares++;
        end
        tick();
        err_clr = 1'b0;
        vectors++;
        if (err_flag !== 1'b0 || LED !== 4'hF) begin
            $display("FAIL err_clear err=%b led=%h exp err=0 led=f", err_flag, LED);
            miscompares++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) mode_sel = 8'($urandom);
            evt_pulse = N'($urandom);
            err_in    = ($urandom_range(0, 39) == 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            duty      = 4'($urandom);
            tick();
            vectors++;
            if (LED !== exp_led || err_flag !== exp_err) begin
                $display("FAIL random k=%0d mode=%h led=%h err=%b exp led=%h err=%b", k, mode_sel, LED, err_flag, exp_led, exp_err);
                miscompares++;
            end
        end
        evt_pulse = '0;
        err_in    = 1'b0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

`ifdef STATUS_LED_PWM_EN
    task automatic test_pwm();
        int on_cnt [N];
        mode_sel = 8'h55;
        duty     = 4'd4;
        for (int i = 0; i < N; i++) on_cnt[i] = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            for (int i = 0; i < N; i++) on_cnt[i] += int'(LED[i]);
            vectors++;
            if (LED !== exp_led) begin
                $display("FAIL pwm4 k=%0d led=%h exp %h", k, LED, exp_led);
                miscompares++;
            end
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (on_cnt[i] != 4) begin
                $display("FAIL pwm4_count ch=%0d got %0d exp 4", i, on_cnt[i]);
                miscompares++;
            end
        end
        duty = 4'd0;
        for (int k = 0; k < 16; k++) begin
            tick();
            vectors++;
            if (LED !== 4'h0) begin
                $display("FAIL pwm0 k=%0d led=%h exp 0", k, LED);
                miscompares++;
            end
        end
    endtask
`else
    task automatic test_pwm();
        mode_sel = 8'h55;
        for (int k = 0; k < 16; k++) begin
            duty = 4'($urandom);
            tick();
            vectors++;
            if (LED !== 4'hF || LED !== exp_led) begin
                $display("FAIL duty_ignored k=%0d led=%h exp f", k, LED);
                miscompares++;
            end
        end
    endtask
`endif

    initial begin
        RST_N     = 1'b0;
        evt_pulse = '0;
        mode_sel  = '0;
        err_in    = 1'b0;
        err_clr   = 1'b0;
        duty      = 4'd0;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #4 RST_N = 1'b1;
        model_reset();

        test_reset();
        test_stretch();
        test_mode_gating();
        test_error();
        test_random();
        test_pwm();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
